// File: rtl/irq_ack_sequencer.sv
// 8259A-style interrupt-acknowledge sequencer: priority resolution, INTA handshake, ISR and vector drive.
// Optional automatic EOI is enabled by defining IRQ_ACK_SEQUENCER_AUTO_EOI_EN (adds the aeoi input).
module irq_ack_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned VEC_DRIVE_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [4:0] vector_base,
    input  logic       inta_n,
    input  logic       eoi_cmd,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
`ifdef IRQ_ACK_SEQUENCER_AUTO_EOI_EN
    input  logic       aeoi,
`endif
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [2:0] lowest_prio,
    output logic       ack_active
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACK1  = 3'd1;
    localparam logic [2:0] S_WAIT2 = 3'd2;
    localparam logic [2:0] S_ACK2  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic [2:0]    state;
    logic [TW-1:0] to_cnt;
    logic [1:0]    hold_cnt;
    logic          prev_inta_n;
    logic [2:0]    ack_level;
    logic          ack_spur;

    logic [7:0] req;
    logic       fall, rise;
    logic       cand_found, top_found, cand_valid;
    logic [2:0] cand_lvl, cand_rank, top_lvl, top_rank, lvl;
    logic       eoi_hit, aeoi_hit, isr_set;
    logic [2:0] eoi_lvl;
    logic [7:0] isr_next;
    logic [2:0] prio_next;

    assign req        = irr & ~imr;
    assign fall       = prev_inta_n & ~inta_n;
    assign rise       = ~prev_inta_n & inta_n;
    assign ack_active = (state != S_IDLE);

    // Scan levels in priority order starting just above lowest_prio; rank 0 is highest.
    always_comb begin
        cand_found = 1'b0;
        cand_lvl   = '0;
        cand_rank  = '0;
        top_found  = 1'b0;
        top_lvl    = '0;
        top_rank   = '0;
        lvl        = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            lvl = lowest_prio + 3'(i + 1);
            if (!cand_found && req[lvl]) begin
                cand_found = 1'b1;
                cand_lvl   = lvl;
                cand_rank  = 3'(i);
            end
            if (!top_found && isr[lvl]) begin
                top_found = 1'b1;
                top_lvl   = lvl;
                top_rank  = 3'(i);
            end
        end
        cand_valid = cand_found && (!top_found || (cand_rank < top_rank));
    end

    always_comb begin
        eoi_hit = 1'b0;
        eoi_lvl = '0;
        if (eoi_cmd) begin
            if (eoi_specific) begin
                eoi_hit = 1'b1;
                eoi_lvl = eoi_level;
            end else if (top_found) begin
                eoi_hit = 1'b1;
                eoi_lvl = top_lvl;
            end
        end
`ifdef IRQ_ACK_SEQUENCER_AUTO_EOI_EN
        aeoi_hit = (state == S_ACK2) && rise && aeoi && !ack_spur;
`else
        aeoi_hit = 1'b0;
`endif
        isr_set = (state == S_IDLE) && fall && cand_valid;

        // Clears first, then the acknowledge set, so a same-bit collision leaves the bit set.
        isr_next = isr;
        if (eoi_hit)  isr_next[eoi_lvl]   = 1'b0;
        if (aeoi_hit) isr_next[ack_level] = 1'b0;
        if (isr_set)  isr_next[cand_lvl]  = 1'b1;

        prio_next = lowest_prio;
        if (aeoi_hit && rotate_on_eoi) prio_next = ack_level;
        if (eoi_hit && rotate_on_eoi)  prio_next = eoi_lvl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            hold_cnt    <= '0;
            prev_inta_n <= 1'b1;
            ack_level   <= '0;
            ack_spur    <= 1'b0;
            isr         <= '0;
            lowest_prio <= 3'd7;
            int_out     <= 1'b0;
            data_out    <= '0;
            data_oe     <= 1'b0;
        end else begin
            prev_inta_n <= inta_n;
            isr         <= isr_next;
            lowest_prio <= prio_next;
            int_out     <= (state == S_IDLE) && cand_valid;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state     <= S_ACK1;
                        ack_level <= cand_valid ? cand_lvl : 3'd7;
                        ack_spur  <= !cand_valid;
                    end
                end
                S_ACK1: begin
                    data_oe <= 1'b0;
                    if (rise) begin
                        state  <= S_WAIT2;
                        to_cnt <= '0;
                    end
                end
                S_WAIT2: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (fall) begin
                        state    <= S_ACK2;
                        data_out <= {vector_base, ack_level};
                        data_oe  <= 1'b1;
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end
                end
                S_ACK2: begin
                    if (rise) begin
                        if (VEC_DRIVE_HOLD == 0) begin
                            data_oe <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 2'd1;
                    if (hold_cnt == 2'(VEC_DRIVE_HOLD - 1)) begin
                        data_oe <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Directed bench for irq_ack_sequencer: handshake, nesting, rotation, spurious, timeout, reset, EOI collisions.
module tb_irq_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr, imr;
    logic [4:0] vector_base;
    logic       inta_n, eoi_cmd, eoi_specific, rotate_on_eoi;
    logic [2:0] eoi_level;
`ifdef IRQ_ACK_SEQUENCER_AUTO_EOI_EN
    logic       aeoi;
`endif
    logic       int_out, data_oe, ack_active;
    logic [7:0] isr, data_out;
    logic [2:0] lowest_prio;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_ack_sequencer #(
        .TIMEOUT_CYCLES(16),
        .VEC_DRIVE_HOLD(0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irr          (irr),
        .imr          (imr),
        .vector_base  (vector_base),
        .inta_n       (inta_n),
        .eoi_cmd      (eoi_cmd),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .rotate_on_eoi(rotate_on_eoi),
`ifdef IRQ_ACK_SEQUENCER_AUTO_EOI_EN
        .aeoi         (aeoi),
`endif
        .int_out      (int_out),
        .isr          (isr),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .lowest_prio  (lowest_prio),
        .ack_active   (ack_active)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the sequencer in WAIT2 with its timeout counter cleared.
    task automatic first_inta();
        inta_n = 1'b0;
        tick();
        tick();
        inta_n = 1'b1;
        tick();
    endtask

    task automatic second_inta(input string tag, input logic [7:0] exp_vec);
        inta_n = 1'b0;
        tick();
        check({tag, "_oe"}, data_oe, 8'h01);
        check({tag, "_vec"}, data_out, exp_vec);
        tick();
        inta_n = 1'b1;
        tick();
        check({tag, "_oe_off"}, data_oe, 8'h00);
        check({tag, "_idle"}, ack_active, 8'h00);
    endtask

    task automatic send_eoi(input logic spec, input logic [2:0] lvl, input logic rot);
        eoi_cmd       = 1'b1;
        eoi_specific  = spec;
        eoi_level     = lvl;
        rotate_on_eoi = rot;
        tick();
        eoi_cmd       = 1'b0;
        eoi_specific  = 1'b0;
        rotate_on_eoi = 1'b0;
    endtask

    initial begin
        logic seen_oe;
        rst_n = 1'b0; irr = '0; imr = '0; vector_base = 5'h08; inta_n = 1'b1;
        eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = '0; rotate_on_eoi = 1'b0;
`ifdef IRQ_ACK_SEQUENCER_AUTO_EOI_EN
        aeoi = 1'b0;
`endif
        tick();
        tick();
        check("rst_isr", isr, 8'h00);
        check("rst_prio", lowest_prio, 8'h07);
        check("rst_int", int_out, 8'h00);
        check("rst_oe", data_oe, 8'h00);
        check("rst_dout", data_out, 8'h00);
        check("rst_active", ack_active, 8'h00);

        // Basic handshake, IR3 beats IR5; irr drops mid-handshake without effect.
        rst_n = 1'b1;
        irr = 8'h28;
        tick();
        check("t1_int", int_out, 8'h01);
        first_inta();
        check("t1_isr", isr, 8'h08);
        check("t1_int_clr", int_out, 8'h00);
        check("t1_active", ack_active, 8'h01);
        irr = 8'h00;
        second_inta("t1", 8'h43);
        irr = 8'h28;
        tick();
        tick();
        check("t1_no_int", int_out, 8'h00);

        // Nesting: IR1 preempts in-service IR3, IR5 does not.
        irr = 8'h2A;
        tick();
        check("t2_int", int_out, 8'h01);
        first_inta();
        check("t2_isr", isr, 8'h0A);
        second_inta("t2", 8'h41);
        send_eoi(1'b0, 3'd0, 1'b0);
        check("t2_eoi", isr, 8'h08);
        irr = 8'h20;
        tick();
        tick();
        check("t2_ir5_blocked", int_out, 8'h00);

        // Rotation: specific EOI on 3 makes IR4 highest.
        send_eoi(1'b1, 3'd3, 1'b1);
        check("t3_isr", isr, 8'h00);
        check("t3_prio", lowest_prio, 8'h03);
        irr = 8'h11;
        tick();
        check("t3_int", int_out, 8'h01);
        first_inta();
        check("t3_isr_ack", isr, 8'h10);
        second_inta("t3", 8'h44);
        send_eoi(1'b1, 3'd4, 1'b0);
        check("t3_eoi", isr, 8'h00);
        check("t3_prio_kept", lowest_prio, 8'h03);

        // Spurious acknowledge.
        irr = 8'h00;
        tick();
        check("t4_int", int_out, 8'h00);
        first_inta();
        check("t4_isr", isr, 8'h00);
        check("t4_active", ack_active, 8'h01);
        second_inta("t4", 8'h47);
        send_eoi(1'b1, 3'd6, 1'b1);
        check("t4_rot_clear_bit", lowest_prio, 8'h06);
        send_eoi(1'b1, 3'd7, 1'b1);
        check("t4_rot_back", lowest_prio, 8'h07);

        // Missing second INTA: abort after 16 clocks in WAIT2.
        irr = 8'h04;
        tick();
        first_inta();
        check("t5_isr", isr, 8'h04);
        seen_oe = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_oe |= data_oe;
        end
        check("t5_still_wait", ack_active, 8'h01);
        tick();
        seen_oe |= data_oe;
        check("t5_timeout", ack_active, 8'h00);
        check("t5_no_oe", seen_oe, 8'h00);
        check("t5_isr_kept", isr, 8'h04);

        // Reset during ACK2.
        send_eoi(1'b1, 3'd2, 1'b0);
        check("t5_eoi", isr, 8'h00);
        tick();
        first_inta();
        inta_n = 1'b0;
        tick();
        check("t5_ack2_oe", data_oe, 8'h01);
        check("t5_ack2_vec", data_out, 8'h42);
        rst_n = 1'b0;
        inta_n = 1'b1;
        tick();
        check("t5_rst_isr", isr, 8'h00);
        check("t5_rst_oe", data_oe, 8'h00);
        check("t5_rst_dout", data_out, 8'h00);
        check("t5_rst_active", ack_active, 8'h00);
        check("t5_rst_int", int_out, 8'h00);
        check("t5_rst_prio", lowest_prio, 8'h07);
        rst_n = 1'b1;
        tick();

        // Set and EOI clear in the same clock: same bit keeps it, different bits both apply.
        inta_n = 1'b0;
        eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        eoi_cmd = 1'b0; eoi_specific = 1'b0;
        check("t6_same_bit", isr, 8'h04);
        tick();
        inta_n = 1'b1;
        tick();
        second_inta("t6a", 8'h42);
        irr = 8'h06;
        inta_n = 1'b0;
        eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        eoi_cmd = 1'b0; eoi_specific = 1'b0;
        check("t6_diff_bits", isr, 8'h02);
        tick();
        inta_n = 1'b1;
        tick();
        second_inta("t6b", 8'h41);
        send_eoi(1'b0, 3'd0, 1'b0);
        check("t6_eoi", isr, 8'h00);

`ifdef IRQ_ACK_SEQUENCER_AUTO_EOI_EN
        aeoi = 1'b1;
        irr = 8'h04;
        tick();
        first_inta();
        check("t7_isr_set", isr, 8'h04);
        second_inta("t7", 8'h42);
        check("t7_aeoi_clear", isr, 8'h00);
        check("t7_prio", lowest_prio, 8'h07);
        aeoi = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
